// File: rtl/idecode_hz_pkg.sv
// Shared decode definitions for idecode_hz: opcodes, control encodings,
// E-stage control bundle and the immediate generator.
package idecode_hz_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7
  } alu_ctrl_e;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_control;
  } ectrl_t;

  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  // 32-bit immediate; the caller sign-extends to the datapath width.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_src_e src);
    case (src)
      IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   imm_gen = {i[31:12], 12'b0};
      default: imm_gen = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/idecode_hz_id_ex_reg.sv
// ID/EX pipeline register: reset > hold > bubble > load.
module id_ex_reg
  import idecode_hz_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_i,
  input  logic            bubble_i,
  input  ectrl_t          ctrl_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  output ectrl_t          ctrl_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o
);

  typedef struct packed {
    ectrl_t          ctrl;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
  } stage_t;

  stage_t stage_d, stage_q;

  // A bubble zeroes the whole stage, so data fields never leak stale values.
  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      if (bubble_i) stage_d = '0;
      else stage_d = '{ctrl_i, rs1_i, rs2_i, rd_i, rd1_i, rd2_i, imm_i, pc_i, pc4_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign ctrl_o = stage_q.ctrl;
  assign rs1_o  = stage_q.rs1;
  assign rs2_o  = stage_q.rs2;
  assign rd_o   = stage_q.rd;
  assign rd1_o  = stage_q.rd1;
  assign rd2_o  = stage_q.rd2;
  assign imm_o  = stage_q.imm;
  assign pc_o   = stage_q.pc;
  assign pc4_o  = stage_q.pc4;

endmodule

// File: rtl/idecode_hz.sv
// RISC-V decode stage with register file, load-use hazard unit and ID/EX register.
// Define IDECODE_HZ_PERF_EN to add the StallCnt/FlushCnt performance counters.
module idecode_hz
  import idecode_hz_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  localparam int RADDR = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            PCSrcE,
  input  logic            HoldE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            ValidE,
  output logic            IllegalE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
`ifdef IDECODE_HZ_PERF_EN
  ,
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt
`endif
);

  logic [6:0] opcode;
  logic [4:0] rs1_d, rs2_d, rd_d;
  assign opcode = InstrD[6:0];
  assign rs1_d  = InstrD[19:15];
  assign rs2_d  = InstrD[24:20];
  assign rd_d   = InstrD[11:7];

  // x0 has no storage; every other register is its own resettable flop bank.
  logic [XLEN-1:0] rf_q [NREG-1:1];
  for (genvar gi = 1; gi < NREG; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (!reset) rf_q[gi] <= '0;
      else if (RegWriteW && RdW == 5'(gi)) rf_q[gi] <= ResultW;
    end
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    rf_read = '0;
    if (idx != 5'd0 && int'(idx) < NREG) begin
      if (RegWriteW && RdW == idx) rf_read = ResultW;
      else                         rf_read = rf_q[idx[RADDR-1:0]];
    end
  endfunction

  ectrl_t          ctrl_dec;
  imm_src_e        imm_src;
  logic            use_rs1, use_rs2, use_rd, bad;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext, rd1_d, rd2_d;

  always_comb begin
    ctrl_dec = '0;
    imm_src  = IMM_I;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; ctrl_dec.result_src = RES_MEM;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src = 1'b1; imm_src = IMM_S;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_control = alu_op(InstrD[14:12], InstrD[30]);
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_IALU: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1;
        ctrl_dec.alu_control = alu_op(InstrD[14:12], 1'b0);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec.branch = 1'b1; ctrl_dec.alu_control = ALU_SUB; imm_src = IMM_B;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = (InstrD[14:13] != 2'b00);  // only beq/bne
      end
      OP_JAL: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.jump = 1'b1; ctrl_dec.result_src = RES_PC4;
        imm_src = IMM_J; use_rd = 1'b1;
      end
      OP_LUI: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; imm_src = IMM_U; use_rd = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if ((use_rs1 && int'(rs1_d) >= NREG) || (use_rs2 && int'(rs2_d) >= NREG) ||
        (use_rd && int'(rd_d) >= NREG))
      bad = 1'b1;
    if (bad) begin
      ctrl_dec = '0;
      ctrl_dec.illegal = 1'b1;
    end
    if (!ValidD) ctrl_dec = '0;
    ctrl_dec.valid = ValidD;
  end

  always_comb begin
    imm32 = imm_gen(InstrD, imm_src);
    imm_ext = {XLEN{imm32[31]}};
    imm_ext[31:0] = imm32;
    rd1_d = rf_read(rs1_d);
    rd2_d = rf_read(rs2_d);
  end

  logic rs2_cmp, lu;
  assign rs2_cmp = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign lu = ValidE && ResultSrcE == RES_MEM && RdE != 5'd0 &&
              (RdE == rs1_d || (rs2_cmp && RdE == rs2_d));

  assign StallF = lu || HoldE;
  assign StallD = lu || HoldE;
  assign FlushD = PCSrcE && !HoldE;

  ectrl_t ctrl_e;

  id_ex_reg #(.XLEN(XLEN)) u_id_ex (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (HoldE),
    .bubble_i (PCSrcE || lu),
    .ctrl_i   (ctrl_dec),
    .rs1_i    (rs1_d),
    .rs2_i    (rs2_d),
    .rd_i     (rd_d),
    .rd1_i    (rd1_d),
    .rd2_i    (rd2_d),
    .imm_i    (imm_ext),
    .pc_i     (PCD),
    .pc4_i    (PCPlus4D),
    .ctrl_o   (ctrl_e),
    .rs1_o    (Rs1E),
    .rs2_o    (Rs2E),
    .rd_o     (RdE),
    .rd1_o    (RD1E),
    .rd2_o    (RD2E),
    .imm_o    (ImmExtE),
    .pc_o     (PCE),
    .pc4_o    (PCPlus4E)
  );

  assign ValidE      = ctrl_e.valid;
  assign IllegalE    = ctrl_e.illegal;
  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ResultSrcE  = ctrl_e.result_src;
  assign ALUControlE = ctrl_e.alu_control;

`ifdef IDECODE_HZ_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu && !HoldE && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (PCSrcE && !HoldE && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
